// File: rtl/conv_tile_sequencer_if.sv
// Bundle between the tile sequencer, its feature-map memories and the convolution core.
// The master modport is the sequencer side; the slave modport is the memory/core side.
interface conv_tile_sequencer_if #(
  parameter int NBITS = 8,
  parameter int IFA_W = 7,
  parameter int OFA_W = 7
);
  logic                        go;
  logic                        busy;
  logic                        done;
  logic                        timeout_err;
  logic                        ifmap_rd;
  logic [IFA_W-1:0]            ifmap_addr;
  logic [NBITS-1:0]            ifmap_data;
  logic                        core_start;
  logic [24:0][NBITS-1:0]      core_inputMAP;
  logic [8:0][NBITS-1:0]       core_outputMAP;
  logic                        core_valid;
  logic                        ofmap_we;
  logic [OFA_W-1:0]            ofmap_addr;
  logic [NBITS-1:0]            ofmap_data;

  modport master (
    input  go, ifmap_data, core_outputMAP, core_valid,
    output busy, done, timeout_err, ifmap_rd, ifmap_addr,
           core_start, core_inputMAP, ofmap_we, ofmap_addr, ofmap_data
  );

  modport slave (
    output go, ifmap_data, core_outputMAP, core_valid,
    input  busy, done, timeout_err, ifmap_rd, ifmap_addr,
           core_start, core_inputMAP, ofmap_we, ofmap_addr, ofmap_data
  );
endinterface

// File: rtl/conv_tile_sequencer.sv
// Cuts an IMG_H x IMG_W feature map into overlapping 5x5 tiles (stride 3), runs each
// through the convolution core and writes the 3x3 results into the output map.
package packConv;
  localparam int NBITS = 8;
  typedef logic [24:0][NBITS-1:0] param25;
  typedef logic [8:0][NBITS-1:0]  param9;
endpackage

// state | meaning
// IDLE  | waiting for go
// LOAD  | 25 reads of the current tile, n=0..25 (capture lags read by one)
// START | one-cycle start pulse to the core
// WAIT  | waiting for core_valid, bounded by WAIT_MAX
// STORE | nine writes of the result buffer, m=0..8
// DONE  | one-cycle done pulse
module conv_tile_sequencer
  import packConv::*;
#(
  parameter int IMG_W    = 11,
  parameter int IMG_H    = 11,
  parameter int WAIT_MAX = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_tile_sequencer_if.master bus
);
  localparam int IFA_W = $clog2(IMG_W*IMG_H);
  localparam int OFA_W = $clog2((IMG_W-2)*(IMG_H-2));
  localparam int CW    = IFA_W;
  localparam int WT_W  = $clog2(WAIT_MAX+1);

  if (((IMG_W-2) % 3) != 0 || ((IMG_H-2) % 3) != 0 || IMG_W < 5 || IMG_H < 5) begin : g_bad_dims
    $error("conv_tile_sequencer: IMG_W-2 and IMG_H-2 must be positive multiples of 3");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STORE, S_DONE} state_t;

  state_t          state, state_nx;
  logic [4:0]      cnt;
  logic [2:0]      sub_r, sub_c;
  logic [CW-1:0]   tr, tc;
  logic [WT_W-1:0] wtmr;
  param25          tile;
  param9           res;
  logic            terr;
  logic            last_col, last_row;
  logic            rd, we;

  assign last_col = (32'(tc) + 32'd3) >= 32'(IMG_W - 2);
  assign last_row = (32'(tr) + 32'd3) >= 32'(IMG_H - 2);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.go) state_nx = S_LOAD;
      S_LOAD:  if (cnt == 5'd25) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.core_valid)    state_nx = S_STORE;
        else if (wtmr == '0)   state_nx = S_IDLE;
      end
      S_STORE: if (cnt == 5'd8) state_nx = (last_col && last_row) ? S_DONE : S_LOAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // sub_r/sub_c walk the 5x5 read window in LOAD and the 3x3 write window in STORE
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      sub_r <= '0;
      sub_c <= '0;
      tr    <= '0;
      tc    <= '0;
      wtmr  <= '0;
      tile  <= '0;
      res   <= '0;
      terr  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.go) begin
            terr  <= 1'b0;
            tr    <= '0;
            tc    <= '0;
            cnt   <= '0;
            sub_r <= '0;
            sub_c <= '0;
          end
        end
        S_LOAD: begin
          if (cnt != 5'd0) tile[cnt - 5'd1] <= bus.ifmap_data;
          if (cnt == 5'd25) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 5'd1;
            if (sub_c == 3'd4) begin
              sub_c <= '0;
              sub_r <= (sub_r == 3'd4) ? 3'd0 : sub_r + 3'd1;
            end else begin
              sub_c <= sub_c + 3'd1;
            end
          end
        end
        S_START: wtmr <= WT_W'(WAIT_MAX - 1);
        S_WAIT: begin
          if (bus.core_valid)  res  <= bus.core_outputMAP;
          else if (wtmr != '0) wtmr <= wtmr - 1'b1;
          else                 terr <= 1'b1;
        end
        S_STORE: begin
          if (cnt == 5'd8) begin
            cnt   <= '0;
            sub_r <= '0;
            sub_c <= '0;
            if (!last_col) begin
              tc <= tc + CW'(3);
            end else if (!last_row) begin
              tc <= '0;
              tr <= tr + CW'(3);
            end
          end else begin
            cnt <= cnt + 5'd1;
            if (sub_c == 3'd2) begin
              sub_c <= '0;
              sub_r <= sub_r + 3'd1;
            end else begin
              sub_c <= sub_c + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd = (state == S_LOAD) && (cnt <= 5'd24);
  assign we = (state == S_STORE);

  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = (state == S_DONE);
  assign bus.timeout_err   = terr;
  assign bus.ifmap_rd      = rd;
  assign bus.ifmap_addr    = rd ? IFA_W'((32'(tr) + 32'(sub_r)) * 32'(IMG_W) + 32'(tc) + 32'(sub_c)) : '0;
  assign bus.core_start    = (state == S_START);
  assign bus.core_inputMAP = tile;
  assign bus.ofmap_we      = we;
  assign bus.ofmap_addr    = we ? OFA_W'((32'(tr) + 32'(sub_r)) * 32'(IMG_W - 2) + 32'(tc) + 32'(sub_c)) : '0;
  assign bus.ofmap_data    = we ? res[cnt[3:0]] : '0;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer: ramp input map, 10-cycle core model,
// scoreboard of expected output-map writes, plus a single-tile 5x5 instance.
module tb_conv_tile_sequencer;
  import packConv::*;

  localparam int W   = 11;
  localparam int H   = 11;
  localparam int WM  = 32;
  localparam int IA  = $clog2(W*H);
  localparam int OA  = $clog2((W-2)*(H-2));
  localparam int IA5 = $clog2(25);
  localparam int OA5 = $clog2(9);
  localparam int CIDX [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

  typedef struct packed {
    logic [15:0]      addr;
    logic [NBITS-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nmis = 0;

  wr_t  sb[$];
  wr_t  sb5[$];
  int   rd_log[$];
  int   wr_log[$];
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   wr5_cnt = 0;

  logic   never_valid = 1'b0;
  logic   spur = 1'b0;
  logic [3:0] lat, lat5;
  logic   mvalid, mvalid5;
  param25 ctile, ctile5;
  param25 snap;
  logic   stab_on = 1'b0;

  conv_tile_sequencer_if #(.NBITS(NBITS), .IFA_W(IA),  .OFA_W(OA))  bus();
  conv_tile_sequencer_if #(.NBITS(NBITS), .IFA_W(IA5), .OFA_W(OA5)) bus5();

  conv_tile_sequencer #(.IMG_W(W), .IMG_H(H), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  conv_tile_sequencer #(.IMG_W(5), .IMG_H(5), .WAIT_MAX(WM)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Input memory: ramp on reads, random garbage otherwise
  always @(posedge clk) begin
    if (bus.ifmap_rd) bus.ifmap_data <= NBITS'(bus.ifmap_addr);
    else              bus.ifmap_data <= NBITS'($urandom);
    if (bus5.ifmap_rd) bus5.ifmap_data <= NBITS'(bus5.ifmap_addr);
    else               bus5.ifmap_data <= NBITS'($urandom);
  end

  // Core models: sample the tile one cycle after start, valid on the 10th cycle
  always @(posedge clk) begin
    if (reset) begin
      lat <= '0; mvalid <= 1'b0; ctile <= '0;
    end else begin
      mvalid <= 1'b0;
      if (bus.core_start)    lat <= 4'd1;
      else if (lat == 4'd9) begin lat <= '0; mvalid <= !never_valid; end
      else if (lat != 4'd0)  lat <= lat + 4'd1;
      if (lat == 4'd1) ctile <= bus.core_inputMAP;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      lat5 <= '0; mvalid5 <= 1'b0; ctile5 <= '0;
    end else begin
      mvalid5 <= 1'b0;
      if (bus5.core_start)    lat5 <= 4'd1;
      else if (lat5 == 4'd9) begin lat5 <= '0; mvalid5 <= 1'b1; end
      else if (lat5 != 4'd0)  lat5 <= lat5 + 4'd1;
      if (lat5 == 4'd1) ctile5 <= bus5.core_inputMAP;
    end
  end

  assign bus.core_valid  = mvalid | spur;
  assign bus5.core_valid = mvalid5;

  always_comb begin
    bus.core_outputMAP  = '0;
    bus5.core_outputMAP = '0;
    for (int k = 0; k < 9; k++) begin
      bus.core_outputMAP[k]  = ctile[CIDX[k]];
      bus5.core_outputMAP[k] = ctile5[CIDX[k]];
    end
  end

  // Output monitor and scoreboard for the 11x11 instance
  always @(negedge clk) begin
    wr_t e;
    if (bus.ifmap_rd) begin
      rd_log.push_back(int'(bus.ifmap_addr));
      chk("rd_we_exclusive", bus.ofmap_we, 1'b0);
    end
    if (bus.ofmap_we) begin
      wr_cnt++;
      wr_log.push_back(int'(bus.ofmap_addr));
      chk("write_expected", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", bus.ofmap_addr, e.addr);
        chk("wr_data", bus.ofmap_data, e.data);
      end
    end
    if (bus.done) done_cnt++;
    if (bus.core_start) begin
      snap    = bus.core_inputMAP;
      stab_on = 1'b1;
    end else if (stab_on) begin
      ncmp++;
      assert (bus.core_inputMAP === snap) else begin
        nmis++;
        $error("FAIL tile_stable: observed %0h expected %0h", bus.core_inputMAP, snap);
      end
      if (bus.core_valid || !bus.busy) stab_on = 1'b0;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (bus5.ofmap_we) begin
      wr5_cnt++;
      chk("write5_expected", 64'(sb5.size() != 0), 1);
      if (sb5.size() != 0) begin
        e = sb5.pop_front();
        chk("wr5_addr", bus5.ofmap_addr, e.addr);
        chk("wr5_data", bus5.ofmap_data, e.data);
      end
    end
  end

  // Expected writes: output pixel (r,c) is input pixel (r+1,c+1) of the ramp
  task automatic push_writes(input int ntiles, input int nm);
    wr_t e;
    int  t, r, c;
    t = 0;
    for (int tr = 0; tr < H-2; tr += 3)
      for (int tc = 0; tc < W-2; tc += 3) begin
        if (t < ntiles)
          for (int m = 0; m < nm; m++) begin
            r = tr + m/3;
            c = tc + m%3;
            e.addr = 16'(r*(W-2) + c);
            e.data = NBITS'((r+1)*W + c + 1);
            sb.push_back(e);
          end
        t++;
      end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},       bus.busy, 0);
    chk({tag, "_done"},       bus.done, 0);
    chk({tag, "_terr"},       bus.timeout_err, 0);
    chk({tag, "_ifmap_rd"},   bus.ifmap_rd, 0);
    chk({tag, "_ifmap_addr"}, bus.ifmap_addr, 0);
    chk({tag, "_core_start"}, bus.core_start, 0);
    chk({tag, "_ofmap_we"},   bus.ofmap_we, 0);
    chk({tag, "_ofmap_addr"}, bus.ofmap_addr, 0);
    chk({tag, "_ofmap_data"}, bus.ofmap_data, 0);
    ncmp++;
    assert (bus.core_inputMAP === '0) else begin
      nmis++;
      $error("FAIL %s_tile: observed %0h expected 0", tag, bus.core_inputMAP);
    end
  endtask

  // Go pulse at cycle 0; optional go glitches and a spurious core_valid at given cycles
  task automatic run_map(input int g1, input int g2, input int sp, output int dcyc);
    int cyc;
    @(negedge clk);
    bus.go = 1'b1;
    cyc  = 0;
    dcyc = -1;
    while (dcyc < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      bus.go = (cyc == g1 || cyc == g2);
      spur   = (cyc == sp);
      if (cyc == 1) begin
        chk("busy_after_go", bus.busy, 1);
        chk("terr_clear_on_go", bus.timeout_err, 0);
      end
      if (bus.done) dcyc = cyc;
    end
    bus.go = 1'b0;
    spur   = 1'b0;
    chk("done_seen", 64'(dcyc >= 0), 1);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
  endtask

  initial begin
    int dc, cyc, n;
    logic found;
    int exp_rd[6];
    int exp_wr[9];
    wr_t e;
    exp_rd = '{3, 4, 5, 6, 7, 14};
    exp_wr = '{3, 4, 5, 12, 13, 14, 21, 22, 23};

    reset   = 1'b1;
    bus.go  = 1'b0;
    bus5.go = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    chk("reset_busy5", bus5.busy, 0);
    reset = 1'b0;

    // Full 11x11 map
    push_writes(9, 9);
    rd_log.delete(); wr_log.delete(); wr_cnt = 0; done_cnt = 0;
    run_map(-1, -1, -1, dc);
    chk("done_cycle", dc, 415);
    chk("read_count", rd_log.size(), 225);
    chk("write_count", wr_cnt, 81);
    chk("sb_drained", sb.size(), 0);
    chk("done_count", done_cnt, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("tile1_rd%0d", i), rd_log[25+i], exp_rd[i]);
    for (int i = 0; i < 9; i++) chk($sformatf("tile1_wr%0d", i), wr_log[9+i], exp_wr[i]);

    // Core never answers
    never_valid = 1'b1;
    wr_cnt = 0; done_cnt = 0;
    @(negedge clk); bus.go = 1'b1;
    @(negedge clk); bus.go = 1'b0;
    repeat (58) @(negedge clk);
    chk("busy_before_timeout", bus.busy, 1);
    chk("terr_before_timeout", bus.timeout_err, 0);
    @(negedge clk);
    chk("terr_at_timeout", bus.timeout_err, 1);
    chk("busy_at_timeout", bus.busy, 0);
    repeat (10) @(negedge clk);
    chk("terr_sticky", bus.timeout_err, 1);
    chk("timeout_no_writes", wr_cnt, 0);
    chk("timeout_no_done", done_cnt, 0);
    never_valid = 1'b0;

    // Recovery with go glitches in LOAD/WAIT and a spurious valid in LOAD
    push_writes(9, 9);
    rd_log.delete(); wr_cnt = 0; done_cnt = 0;
    run_map(5, 30, 10, dc);
    chk("recover_done_cycle", dc, 415);
    chk("recover_write_count", wr_cnt, 81);
    chk("recover_read_count", rd_log.size(), 225);
    chk("recover_sb_drained", sb.size(), 0);

    // Reset during STORE m=4 of the first tile
    push_writes(1, 5);
    wr_cnt = 0;
    @(negedge clk); bus.go = 1'b1;
    @(negedge clk); bus.go = 1'b0;
    cyc = 1; found = 1'b0;
    while (!found && cyc < 200) begin
      if (bus.ofmap_we && bus.ofmap_addr == OA'(10)) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("store_m4_reached", found, 1);
    chk("store_m4_cycle", cyc, 42);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    reset = 1'b0;
    chk("writes_before_reset", wr_cnt, 5);
    chk("reset_sb_drained", sb.size(), 0);
    n = rd_log.size();
    repeat (5) @(negedge clk);
    chk("no_writes_after_reset", wr_cnt, 5);
    chk("no_reads_after_reset", rd_log.size(), n);

    push_writes(9, 9);
    rd_log.delete(); wr_cnt = 0;
    run_map(-1, -1, -1, dc);
    chk("restart_done_cycle", dc, 415);
    for (int i = 0; i < 3; i++) chk($sformatf("restart_rd%0d", i), rd_log[i], i);
    chk("restart_write_count", wr_cnt, 81);
    chk("restart_sb_drained", sb.size(), 0);

    // Single-tile 5x5 instance
    for (int m = 0; m < 9; m++) begin
      e.addr = 16'(m);
      e.data = NBITS'((m/3 + 1)*5 + m%3 + 1);
      sb5.push_back(e);
    end
    @(negedge clk); bus5.go = 1'b1;
    cyc = 0; dc = -1;
    while (dc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus5.go = 1'b0;
      if (bus5.done) dc = cyc;
    end
    chk("done5_cycle", dc, 47);
    chk("write5_count", wr5_cnt, 9);
    chk("sb5_drained", sb5.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
